ps2_scan_decoder: RTL and testbench

- Sits directly downstream of the PS/2 receiver and consumes its rx_data / rx_done_tick byte stream.
- Assembles Set-2 scan-code sequences (plain, E0-extended, F0-break, E1 pause) into one key event per key action.
- Tracks shift and caps-lock state and emits an ASCII translation for printable and basic control keys.
- Feeds the keyboard text/command logic.

---
 rtl/ps2_scan_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 sequences into key events, tracks shift/caps,
// and translates printable presses to ASCII. Optional build macro: PS2_REPEAT_FILTER_EN.
module ps2_scan_decoder #(
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       ascii_valid,
  output logic [7:0] ascii,
  output logic       shift_on,
  output logic       caps_on
);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

  state_e     state_q, state_d;
  logic [7:0] skip_q, skip_d;

  logic ev_raw, ev_break, ev_ext, ev_fire, suppress;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic caps_held_q, caps_held_d, caps_d;
  logic map_hit, press_map;
  logic [7:0] map_char;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      skip_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (rx_done_tick) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == 8'hE0) begin
            state_d = StExt;
          end else if (rx_data == 8'hF0) begin
            state_d = StBrk;
          end else if (rx_data == 8'hE1) begin
            state_d = StSkip;
            skip_d  = 8'(PAUSE_SKIP);
          end
        end
        StExt: begin
          if (rx_data == 8'hF0) begin
            state_d = StExtBrk;
          end else if (rx_data != 8'hE0) begin
            state_d = StIdle;
          end
        end
        StBrk:    state_d = StIdle;
        StExtBrk: state_d = StIdle;
        StSkip: begin
          skip_d = skip_q - 8'd1;
          // <= 1 also guards against a zero load hanging here
          if (skip_q <= 8'd1) state_d = StIdle;
        end
        default:  state_d = StIdle;
      endcase
    end
  end

  // Event decode from current state and incoming byte
  always_comb begin
    ev_raw   = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (rx_done_tick) begin
      unique case (state_q)
        StIdle: begin
          unique case (rx_data)
            8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00: ev_raw = 1'b0;
            default: ev_raw = 1'b1;
          endcase
        end
        StExt: begin
          ev_ext = 1'b1;
          ev_raw = (rx_data != 8'hF0) && (rx_data != 8'hE0) && (rx_data != 8'h12);
        end
        StBrk: begin
          ev_raw   = 1'b1;
          ev_break = 1'b1;
        end
        StExtBrk: begin
          ev_ext   = 1'b1;
          ev_break = 1'b1;
          ev_raw   = (rx_data != 8'h12);
        end
        default: ev_raw = 1'b0;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] last_code_q;
  logic       last_ext_q, last_vld_q;
  logic       last_match;

  assign last_match = last_vld_q && (last_code_q == rx_data) && (last_ext_q == ev_ext);
  assign suppress   = ev_raw && !ev_break && last_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code_q <= 8'd0;
      last_ext_q  <= 1'b0;
      last_vld_q  <= 1'b0;
    end else if (ev_fire) begin
      if (!ev_break) begin
        last_code_q <= rx_data;
        last_ext_q  <= ev_ext;
        last_vld_q  <= 1'b1;
      end else if (last_match) begin
        last_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign ev_fire = ev_raw && !suppress;

  // ASCII lookup uses the modifier state before this event's update
  always_comb begin
    map_hit  = 1'b1;
    map_char = 8'h00;
    unique case (rx_data)
      8'h1C: map_char = "a";  8'h32: map_char = "b";  8'h21: map_char = "c";
      8'h23: map_char = "d";  8'h24: map_char = "e";  8'h2B: map_char = "f";
      8'h34: map_char = "g";  8'h33: map_char = "h";  8'h43: map_char = "i";
      8'h3B: map_char = "j";  8'h42: map_char = "k";  8'h4B: map_char = "l";
      8'h3A: map_char = "m";  8'h31: map_char = "n";  8'h44: map_char = "o";
      8'h4D: map_char = "p";  8'h15: map_char = "q";  8'h2D: map_char = "r";
      8'h1B: map_char = "s";  8'h2C: map_char = "t";  8'h3C: map_char = "u";
      8'h2A: map_char = "v";  8'h1D: map_char = "w";  8'h22: map_char = "x";
      8'h35: map_char = "y";  8'h1A: map_char = "z";
      8'h16: map_char = shift_on ? "!" : "1";
      8'h1E: map_char = shift_on ? "@" : "2";
      8'h26: map_char = shift_on ? "#" : "3";
      8'h25: map_char = shift_on ? "$" : "4";
      8'h2E: map_char = shift_on ? "%" : "5";
      8'h36: map_char = shift_on ? "^" : "6";
      8'h3D: map_char = shift_on ? "&" : "7";
      8'h3E: map_char = shift_on ? "*" : "8";
      8'h46: map_char = shift_on ? "(" : "9";
      8'h45: map_char = shift_on ? ")" : "0";
      8'h29: map_char = 8'h20;
      8'h5A: map_char = 8'h0D;
      8'h66: map_char = 8'h08;
      8'h0D: map_char = 8'h09;
      8'h76: map_char = 8'h1B;
      default: map_hit = 1'b0;
    endcase
    if (map_char >= "a" && map_char <= "z" && (shift_on ^ caps_on)) begin
      map_char = map_char - 8'h20;
    end
  end

  assign press_map = ev_fire && !ev_break && !ev_ext && map_hit;

  // Modifier tracking, non-extended codes only
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_on;
    if (ev_fire && !ev_ext) begin
      if (rx_data == 8'h12) lshift_d = !ev_break;
      if (rx_data == 8'h59) rshift_d = !ev_break;
      if (rx_data == 8'h58) begin
        if (ev_break) begin
          caps_held_d = 1'b0;
        end else begin
          if (!caps_held_q) caps_d = !caps_on;
          caps_held_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= 8'd0;
      key_break   <= 1'b0;
      key_ext     <= 1'b0;
      ascii_valid <= 1'b0;
      ascii       <= 8'd0;
      shift_on    <= 1'b0;
      caps_on     <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      key_valid   <= ev_fire;
      ascii_valid <= press_map;
      if (ev_fire) begin
        key_code  <= rx_data;
        key_break <= ev_break;
        key_ext   <= ev_ext;
        ascii     <= press_map ? map_char : 8'h00;
      end
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      shift_on    <= lshift_d | rshift_d;
      caps_on     <= caps_d;
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder; expected values are hand-computed from Set-2 codes.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       key_valid, key_break, key_ext, ascii_valid, shift_on, caps_on;
  logic [7:0] key_code, ascii;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_cnt  = 0;
  int c0;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.PAUSE_SKIP(7)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .key_valid(key_valid), .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .ascii_valid(ascii_valid), .ascii(ascii), .shift_on(shift_on), .caps_on(caps_on)
  );

  always @(negedge clk) if (key_valid) ev_cnt++;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte is clocked in at the posedge; the result is visible at the following negedge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int exp_rep;

  initial begin
    idle(2);
    check_eq("rst_key_valid", 16'(key_valid), 16'd0);
    check_eq("rst_key_code", 16'(key_code), 16'h00);
    check_eq("rst_ascii", 16'(ascii), 16'h00);
    check_eq("rst_mods", 16'({shift_on, caps_on, key_break, key_ext, ascii_valid}), 16'd0);
    reset = 1'b0;
    idle(1);

    // Plain press
    send(8'h1C);
    check_eq("a_valid", 16'(key_valid), 16'd1);
    check_eq("a_code", 16'(key_code), 16'h1C);
    check_eq("a_brk_ext", 16'({key_break, key_ext}), 16'd0);
    check_eq("a_ascii", 16'(ascii), 16'h61);
    check_eq("a_ascii_valid", 16'(ascii_valid), 16'd1);
    idle(1);
    check_eq("a_strobe_end", 16'({key_valid, ascii_valid}), 16'd0);
    check_eq("a_code_hold", 16'(key_code), 16'h1C);
    send(8'hF0); send(8'h1C);

    // Shifted letter
    send(8'h12);
    check_eq("lsh_press", 16'({key_valid, key_code, shift_on, ascii_valid}), {6'd0, 1'b1, 8'h12, 1'b1, 1'b0});
    send(8'h1C);
    check_eq("A_ascii", 16'({ascii_valid, ascii}), {7'd0, 1'b1, 8'h41});
    send(8'hF0);
    check_eq("f0_no_event", 16'(key_valid), 16'd0);
    send(8'h1C);
    check_eq("A_release", 16'({key_valid, key_break, ascii_valid, ascii}), {5'd0, 3'b110, 8'h00});
    send(8'hF0); send(8'h12);
    check_eq("lsh_release", 16'({key_break, shift_on}), 16'b10);

    // Extended press and release
    send(8'hE0); send(8'h75);
    check_eq("ext_press", 16'({key_valid, key_ext, key_break, ascii_valid, key_code}), {4'd0, 4'b1100, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75);
    check_eq("ext_release", 16'({key_valid, key_ext, key_break, ascii_valid, key_code}), {4'd0, 4'b1110, 8'h75});

    // Fake shift and ack bytes produce nothing
    idle(2); c0 = ev_cnt;
    send(8'hE0); send(8'h12); send(8'hFA); send(8'hAA);
    idle(2);
    check_eq("discard_cnt", 16'(ev_cnt - c0), 16'd0);
    check_eq("fake_shift", 16'(shift_on), 16'd0);

    // Caps lock with auto-repeat
    send(8'h58);
    check_eq("caps_on1", 16'(caps_on), 16'd1);
    send(8'h58);
    check_eq("caps_repeat", 16'(caps_on), 16'd1);
    send(8'hF0); send(8'h58);
    check_eq("caps_release", 16'(caps_on), 16'd1);
    send(8'h1C);
    check_eq("caps_A", 16'(ascii), 16'h41);
    send(8'hF0); send(8'h1C);
    send(8'h16);
    check_eq("digit1", 16'(ascii), 16'h31);
    send(8'hF0); send(8'h16);
    send(8'h59);
    check_eq("rsh_press", 16'(shift_on), 16'd1);
    send(8'h16);
    check_eq("bang", 16'(ascii), 16'h21);
    send(8'h1C);
    check_eq("caps_shift_a", 16'(ascii), 16'h61);
    send(8'hF0); send(8'h59);
    check_eq("rsh_release", 16'(shift_on), 16'd0);
    send(8'h5A);
    check_eq("enter", 16'(ascii), 16'h0D);

    // Pause sequence
    idle(2); c0 = ev_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(2);
    check_eq("pause_cnt", 16'(ev_cnt - c0), 16'd0);
    send(8'h29);
    check_eq("space", 16'({key_valid, ascii_valid, ascii}), {6'd0, 2'b11, 8'h20});

    // Reset mid-sequence
    send(8'hF0);
    reset = 1'b1;
    idle(2);
    check_eq("mid_rst_out", 16'({key_valid, caps_on, shift_on, ascii}), 16'd0);
    reset = 1'b0;
    idle(1);
    send(8'h1C);
    check_eq("post_rst_press", 16'({key_valid, key_break, key_code}), {7'd0, 2'b10, 8'h1C});
    check_eq("post_rst_ascii", 16'(ascii), 16'h61);

    // Typematic repeat
`ifdef PS2_REPEAT_FILTER_EN
    exp_rep = 1;
`else
    exp_rep = 2;
`endif
    send(8'hF0); send(8'h1C);
    idle(2); c0 = ev_cnt;
    send(8'h1C); send(8'h1C);
    idle(2);
    check_eq("repeat_cnt", 16'(ev_cnt - c0), 16'(exp_rep));
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    check_eq("after_rel_press", 16'(key_valid), 16'd1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
